score_controller: RTL
=====================

// Module: score_controller
// PURPOSE
//  Game-flow controller for the Pong datapath. Counts goal events from the ball
//  logic and sequences serve, point-pause and game-over. Holds both player
//  scores in registers and drives the 4-bit score inputs of the 7-seg refresh
//  block, plus ball_reset and serve direction to the ball/paddle logic.
// PARAMETERS
//  WIN_SCORE     3     score (1..9) that ends the game
//  PAUSE_CYCLES  50_000_000  CLK cycles the ball is held after each point (>=1)
//  BLINK_CYCLES  25_000_000  half-period of winner-score blink (>=1)
// PORTS
//  CLK        in   1  system clock; all logic on posedge
//  RESET      in   1  synchronous reset, active-high
//  start      in   1  1-cycle pulse from button debouncer
//  p1_goal    in   1  1-cycle pulse: player 1 scored
//  p2_goal    in   1  1-cycle pulse: player 2 scored
//  p1_score   out  4  player 1 score, binary 0..9, to display
//  p2_score   out  4  player 2 score, binary 0..9, to display
//  ball_reset out  1  1 = hold ball at centre
//  serve_dir  out  1  0 = serve toward P1, 1 = serve toward P2
//  game_over  out  1  1 while in OVER
//  winner     out  1  0 = P1, 1 = P2; valid while game_over=1
//  blank      out  2  per-digit display blank {p1,p2}; 1 = digit off
// BEHAVIOUR
//  Reset: state IDLE, p1_score=p2_score=0, ball_reset=1, serve_dir=0,
//   game_over=0, winner=0, blank=2'b00, pause and blink counters 0.
//  All outputs registered; respond 1 cycle after the causing input edge.
//  States:
//   IDLE : ball_reset=1, scores held at 0. start -> PLAY.
//   PLAY : ball_reset=0. Goal handling (one cycle):
//     p1_goal only -> p1_score+1, serve_dir=1 (toward loser P2), -> PAUSE
//     p2_goal only -> p2_score+1, serve_dir=0, -> PAUSE
//     both same cycle -> no score change, serve_dir unchanged, -> PAUSE
//     start ignored.
//   PAUSE: ball_reset=1; counter counts 0..PAUSE_CYCLES-1, then: if either
//     score == WIN_SCORE -> OVER (winner = that player) else -> PLAY.
//     Counter cleared on entry. Exactly PAUSE_CYCLES cycles spent in PAUSE.
//   OVER : ball_reset=1, game_over=1. start -> IDLE with both scores cleared to
//     0 and game_over=0 on the same edge.
//  Goal pulses outside PLAY are ignored (no score change, no state change).
//  Score never exceeds WIN_SCORE; no wrap-around is possible since PLAY is
//  only re-entered when both scores < WIN_SCORE.
//  RESET asserted in any state (incl. mid-PAUSE) wins over all other inputs
//  and restores the reset values on that edge.
//  blank=2'b00 in every state unless SCORE_BLINK_EN is defined.
// CONFIGURATION
//  `SCORE_BLINK_EN defined: in OVER, blink counter runs 0..BLINK_CYCLES-1 and
//   toggles the winner's blank bit on wrap (first toggle to 1 after
//   BLINK_CYCLES cycles in OVER); loser's bit stays 0. Counter and blank
//   cleared on leaving OVER and on RESET.
//  Not defined: blink counter not instantiated; blank tied to 2'b00.
// TESTING  (WIN_SCORE=3, PAUSE_CYCLES=4, BLINK_CYCLES=2)
//  RESET 1 cycle, no start -> p1/p2_score=0, ball_reset=1, game_over=0
//   indefinitely; goal pulses ignored.
//  start, then p1_goal -> next edge p1_score=1, serve_dir=1, ball_reset=1 for
//   exactly 4 cycles, then ball_reset=0.
//  p1_goal and p2_goal same cycle in PLAY -> scores unchanged, 4-cycle pause.
//  p2 scores 3 times -> after final pause game_over=1, winner=1, p2_score=3;
//   further goals ignored; start -> scores 0, game_over=0, state IDLE.
//  RESET during PAUSE (cycle 2 of 4) -> all outputs to reset values next edge.
//  With SCORE_BLINK_EN, P1 wins -> blank[1] toggles every 2 cycles, blank[0]=0;
//   without it blank stays 2'b00.

Source files
------------

// File: rtl/score_controller.sv
// score_controller: Pong game-flow controller. Counts goals, sequences
// serve / point-pause / game-over and holds both player scores for display.
// Optional build macro SCORE_BLINK_EN: blinks the winner's score digit in OVER;
// when undefined the blank outputs are tied to 2'b00.
//
// state | meaning
// IDLE  | waiting for start, ball held, scores 0
// PLAY  | ball live, watching for goals
// PAUSE | ball held for PAUSE_CYCLES after a point
// OVER  | someone reached WIN_SCORE, waiting for start
module score_controller #(
  parameter int WIN_SCORE    = 3,
  parameter int PAUSE_CYCLES = 50_000_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       p1_goal,
  input  logic       p2_goal,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] blank
);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;

  localparam int PW = $clog2(PAUSE_CYCLES + 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_CYCLES - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] pause_cnt, pause_cnt_nxt;
  logic [3:0]    p1_nxt, p2_nxt;
  logic          serve_nxt, winner_nxt, ball_reset_nxt, game_over_nxt;

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    state_nxt     = state;
    pause_cnt_nxt = '0;
    p1_nxt        = p1_score;
    p2_nxt        = p2_score;
    serve_nxt     = serve_dir;
    winner_nxt    = winner;
    case (state)
      IDLE: begin
        if (start) state_nxt = PLAY;
      end
      PLAY: begin
        if (p1_goal && !p2_goal) begin
          p1_nxt    = p1_score + 4'd1;
          serve_nxt = 1'b1;
          state_nxt = PAUSE;
        end else if (p2_goal && !p1_goal) begin
          p2_nxt    = p2_score + 4'd1;
          serve_nxt = 1'b0;
          state_nxt = PAUSE;
        end else if (p1_goal && p2_goal) begin
          // Simultaneous goals cancel out but still cost a pause.
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (pause_cnt == PAUSE_LAST) begin
          if (p1_score == WIN) begin
            state_nxt  = OVER;
            winner_nxt = 1'b0;
          end else if (p2_score == WIN) begin
            state_nxt  = OVER;
            winner_nxt = 1'b1;
          end else begin
            state_nxt = PLAY;
          end
        end else begin
          pause_cnt_nxt = pause_cnt + 1'b1;
        end
      end
      OVER: begin
        if (start) begin
          state_nxt = IDLE;
          p1_nxt    = 4'd0;
          p2_nxt    = 4'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    ball_reset_nxt = (state_nxt != PLAY);
    game_over_nxt  = (state_nxt == OVER);
  end

  // State and registered outputs; RESET overrides everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      pause_cnt  <= '0;
      p1_score   <= 4'd0;
      p2_score   <= 4'd0;
      ball_reset <= 1'b1;
      serve_dir  <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pause_cnt  <= pause_cnt_nxt;
      p1_score   <= p1_nxt;
      p2_score   <= p2_nxt;
      ball_reset <= ball_reset_nxt;
      serve_dir  <= serve_nxt;
      game_over  <= game_over_nxt;
      winner     <= winner_nxt;
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt;

  // Winner's digit toggles every BLINK_CYCLES while in OVER; cleared on exit.
  always_ff @(posedge CLK) begin
    if (RESET || state_nxt != OVER) begin
      blink_cnt <= '0;
      blank     <= 2'b00;
    end else if (state == OVER) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blank     <= blank ^ (winner ? 2'b01 : 2'b10);
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  assign blank = 2'b00;
`endif

endmodule
